// File: rtl/layer_sequencer.sv
// Layer controller that time-multiplexes one 3-input neuron across N_NEURON neurons.
// It holds the per-neuron weights and bias, feeds them one neuron per cycle, and collects the outputs.
module layer_sequencer #(
    parameter int WIDTH    = 32,
    parameter int N_NEURON = 4,
    parameter int IDX_W    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in_1,
    input  logic [WIDTH-1:0] a_in_2,
    input  logic [WIDTH-1:0] a_in_3,
    input  logic             cfg_we,
    input  logic [IDX_W+1:0] cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    output logic [WIDTH-1:0] n_a_1,
    output logic [WIDTH-1:0] n_a_2,
    output logic [WIDTH-1:0] n_a_3,
    output logic [WIDTH-1:0] n_w_1,
    output logic [WIDTH-1:0] n_w_2,
    output logic [WIDTH-1:0] n_w_3,
    output logic [WIDTH-1:0] n_b,
    output logic             n_enable,
    input  logic [WIDTH-1:0] n_y,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] feed_idx_reg, feed_idx_next;
    logic             drain_reg, drain_next;

    // Word order per neuron: 0=w_1, 1=w_2, 2=w_3, 3=b.
    logic [WIDTH-1:0] cfg_mem [N_NEURON][4];
    logic [WIDTH-1:0] a_lat   [3];
    logic [WIDTH-1:0] result  [N_NEURON];

    // Capture delay line matching the neuron's 2-cycle pipeline.
    logic             v1_reg, v2_reg;
    logic [IDX_W-1:0] i1_reg, i2_reg;

    logic             cfg_ok;
    logic [IDX_W-1:0] cfg_idx;
    logic [1:0]       cfg_word;
    logic [WIDTH-1:0] sel_w [4];

    assign cfg_idx  = cfg_addr[IDX_W+1:2];
    assign cfg_word = cfg_addr[1:0];
    assign cfg_ok   = cfg_we && (state_reg == IDLE || state_reg == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            feed_idx_reg <= '0;
            drain_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            feed_idx_reg <= feed_idx_next;
            drain_reg    <= drain_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        feed_idx_next = feed_idx_reg;
        drain_next    = drain_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = FEED;
                    feed_idx_next = '0;
                end
            end
            FEED: begin
                feed_idx_next = feed_idx_reg + 1'b1;
                if (feed_idx_reg == IDX_W'(N_NEURON - 1)) begin
                    state_next = DRAIN;
                    drain_next = 1'b0;
                end
            end
            DRAIN: begin
                drain_next = 1'b1;
                if (drain_reg) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_NEURON; k++)
                for (int w = 0; w < 4; w++)
                    cfg_mem[k][w] <= '0;
        end else if (cfg_ok) begin
            // Indices at or beyond N_NEURON match no entry and are dropped.
            for (int k = 0; k < N_NEURON; k++)
                for (int w = 0; w < 4; w++)
                    if (cfg_idx == IDX_W'(k) && cfg_word == 2'(w))
                        cfg_mem[k][w] <= cfg_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < 3; j++) a_lat[j] <= '0;
        end else if (state_reg == IDLE && start) begin
            a_lat[0] <= a_in_1;
            a_lat[1] <= a_in_2;
            a_lat[2] <= a_in_3;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            i1_reg <= '0;
            i2_reg <= '0;
        end else begin
            v1_reg <= (state_reg == FEED);
            i1_reg <= feed_idx_reg;
            v2_reg <= v1_reg;
            i2_reg <= i1_reg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_NEURON; k++) result[k] <= '0;
        end else if (v2_reg) begin
            for (int k = 0; k < N_NEURON; k++)
                if (i2_reg == IDX_W'(k)) result[k] <= n_y;
        end
    end

    // Operand mux: weights and bias are only driven while feeding.
    always_comb begin
        for (int w = 0; w < 4; w++) sel_w[w] = '0;
        if (state_reg == FEED) begin
            for (int k = 0; k < N_NEURON; k++)
                if (feed_idx_reg == IDX_W'(k))
                    for (int w = 0; w < 4; w++) sel_w[w] = cfg_mem[k][w];
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N_NEURON; k++)
            if (rd_idx == IDX_W'(k)) rd_data = result[k];
    end

    assign n_a_1    = a_lat[0];
    assign n_a_2    = a_lat[1];
    assign n_a_3    = a_lat[2];
    assign n_w_1    = sel_w[0];
    assign n_w_2    = sel_w[1];
    assign n_w_3    = sel_w[2];
    assign n_b      = sel_w[3];
    assign busy     = (state_reg == FEED) || (state_reg == DRAIN);
    assign n_enable = busy;
    assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: a 2-stage Q8.24 neuron stub, a cycle-count model of a run,
// and directed runs covering config, alignment, ignored inputs, mid-run reset and back-to-back starts.
module tb_layer_sequencer;
    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a_in_1 = '0, a_in_2 = '0, a_in_3 = '0;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic [31:0] n_a_1, n_a_2, n_a_3, n_w_1, n_w_2, n_w_3, n_b;
    logic        n_enable;
    logic [31:0] n_y;
    logic [2:0]  rd_idx = '0;
    logic [31:0] rd_data;
    logic        busy, done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    layer_sequencer #(.WIDTH(32), .N_NEURON(N), .IDX_W(3)) dut (
        .clock(clock), .reset(reset), .start(start),
        .a_in_1(a_in_1), .a_in_2(a_in_2), .a_in_3(a_in_3),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .n_a_1(n_a_1), .n_a_2(n_a_2), .n_a_3(n_a_3),
        .n_w_1(n_w_1), .n_w_2(n_w_2), .n_w_3(n_w_3), .n_b(n_b),
        .n_enable(n_enable), .n_y(n_y),
        .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] w);
        longint p;
        p = longint'($signed(a)) * longint'($signed(w));
        return 32'(p >>> 24);
    endfunction

    function automatic logic [31:0] neuron_f(input logic [31:0] a1, a2, a3, w1, w2, w3, b);
        return qmul(a1, w1) + qmul(a2, w2) + qmul(a3, w3) + b;
    endfunction

    // Neuron stand-in: y = sum(a*w) + b, two registered stages.
    logic [31:0] stub_s1;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            stub_s1 <= '0;
            n_y     <= '0;
        end else begin
            stub_s1 <= n_enable ? neuron_f(n_a_1, n_a_2, n_a_3, n_w_1, n_w_2, n_w_3, n_b) : 32'h0;
            n_y     <= stub_s1;
        end
    end

    // Model: a run is counted in cycles j after the start edge; busy for j<N+2, done at j=N+2,
    // result[k] takes its new value at the edge leaving j=k+2.
    logic        m_run;
    int          m_j;
    logic [31:0] m_a   [3];
    logic [31:0] m_cfg [N][4];
    logic [31:0] m_res [N];
    logic [31:0] m_new [N];
    int          m_ci;
    assign m_ci = int'(cfg_addr[4:2]);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_run <= 1'b0;
            m_j   <= 0;
            for (int j = 0; j < 3; j++) m_a[j] <= '0;
            for (int k = 0; k < N; k++) begin
                m_res[k] <= '0;
                m_new[k] <= '0;
                for (int w = 0; w < 4; w++) m_cfg[k][w] <= '0;
            end
        end else begin
            if (cfg_we && (!m_run || m_j == N + 2) && m_ci < N)
                m_cfg[m_ci][cfg_addr[1:0]] <= cfg_data;
            if (!m_run) begin
                if (start) begin
                    m_run <= 1'b1;
                    m_j   <= 0;
                    m_a[0] <= a_in_1; m_a[1] <= a_in_2; m_a[2] <= a_in_3;
                    for (int k = 0; k < N; k++)
                        m_new[k] <= neuron_f(a_in_1, a_in_2, a_in_3,
                                             m_cfg[k][0], m_cfg[k][1], m_cfg[k][2], m_cfg[k][3]);
                end
            end else begin
                if (m_j >= 2 && m_j <= N + 1) m_res[m_j - 2] <= m_new[m_j - 2];
                if (m_j == N + 2) m_run <= 1'b0;
                else m_j <= m_j + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process, opposite edge.
    always @(negedge clock) begin
        logic        e_busy, e_done, e_feed;
        logic [31:0] e_w [4];
        e_busy = m_run && (m_j <= N + 1);
        e_done = m_run && (m_j == N + 2);
        e_feed = m_run && (m_j < N);
        for (int w = 0; w < 4; w++) e_w[w] = e_feed ? m_cfg[m_j][w] : 32'h0;
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("n_enable", 32'(n_enable), 32'(e_busy));
        chk("n_a_1", n_a_1, m_a[0]);
        chk("n_a_2", n_a_2, m_a[1]);
        chk("n_a_3", n_a_3, m_a[2]);
        chk("n_w_1", n_w_1, e_w[0]);
        chk("n_w_2", n_w_2, e_w[1]);
        chk("n_w_3", n_w_3, e_w[2]);
        chk("n_b", n_b, e_w[3]);
        chk("rd_data", rd_data, m_res[rd_idx]);
    end

    task automatic tick();
        @(posedge clock);
        #2;
        rd_idx = (rd_idx == 3'(N - 1)) ? 3'd0 : rd_idx + 3'd1;
    endtask

    task automatic cfg_write(input int idx, input int word, input logic [31:0] data);
        cfg_we   = 1'b1;
        cfg_addr = 5'(idx * 4 + word);
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic cfg_ramp();
        for (int k = 0; k < N; k++) begin
            cfg_write(k, 0, 32'(k + 1) << 24);
            cfg_write(k, 1, 32'h0);
            cfg_write(k, 2, 32'h0);
            cfg_write(k, 3, 32'h0);
        end
    endtask

    // Starts a run and measures start-to-done latency, busy width and done width.
    task automatic run_measure(input int disturb);
        int lat, busy_n;
        bit found;
        lat = -1; busy_n = 0; found = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (busy) busy_n++;
            if (done) begin
                found = 1'b1;
                lat = c;
            end else begin
                if (disturb != 0 && c == 1) start = 1'b1;
                if (disturb != 0 && c == 2) start = 1'b0;
                if (disturb != 0 && c == 4) begin
                    cfg_we = 1'b1; cfg_addr = 5'd3; cfg_data = 32'h7fff_ffff;
                end
                if (disturb != 0 && c == 5) cfg_we = 1'b0;
                tick();
            end
        end
        chk("done_latency", 32'(lat), 32'd6);
        chk("busy_cycles", 32'(busy_n), 32'd6);
        tick();
        chk("done_width", 32'(done), 32'd0);
    endtask

    task automatic check_results(input string name, input logic [31:0] step, input int offset);
        for (int k = 0; k < N; k++) begin
            rd_idx = 3'(k);
            #1;
            chk(name, rd_data, 32'(k + offset) * step);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int dt [$];
        tick();
        tick();
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_n_enable", 32'(n_enable), 32'd0);
        chk("reset_n_b", n_b, 32'h0);
        reset = 1'b0;
        tick();

        // Config readback: bias only, identity through the stub.
        for (int k = 0; k < N; k++) begin
            cfg_write(k, 0, 32'h0);
            cfg_write(k, 1, 32'h0);
            cfg_write(k, 2, 32'h0);
            cfg_write(k, 3, 32'(k) * 32'h0010_0000);
        end
        a_in_1 = 32'h0100_0000; a_in_2 = 32'h0100_0000; a_in_3 = 32'h0100_0000;
        run_measure(0);
        check_results("cfg_readback", 32'h0010_0000, 0);
        tick();

        // Pipeline alignment: result[k] = 0.5*(k+1).
        cfg_ramp();
        cfg_write(5, 3, 32'h1234_5678);
        a_in_1 = 32'h0080_0000;
        run_measure(0);
        check_results("align", 32'h0080_0000, 1);
        tick();

        // All-zero neuron.
        for (int k = 0; k < N; k++)
            for (int w = 0; w < 4; w++) cfg_write(k, w, 32'h0);
        run_measure(0);
        check_results("zero", 32'h0, 0);
        tick();

        // Start during FEED and cfg_we during DRAIN must both be ignored.
        cfg_ramp();
        run_measure(1);
        check_results("ignore_run1", 32'h0080_0000, 1);
        tick();
        run_measure(0);
        check_results("ignore_run2", 32'h0080_0000, 1);
        tick();

        // Reset in FEED cycle 2: outputs clear before any clock edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_n_enable", 32'(n_enable), 32'd0);
        chk("rst_n_w_1", n_w_1, 32'h0);
        chk("rst_n_a_1", n_a_1, 32'h0);
        check_results("rst_results", 32'h0, 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 1) reset = 1'b0;
            chk("rst_no_done", 32'(done), 32'd0);
        end
        cfg_ramp();
        run_measure(0);
        check_results("post_reset", 32'h0080_0000, 1);
        tick();

        // Back-to-back: start held; the input changes after the first run is accepted.
        start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 2) a_in_1 = 32'h0040_0000;
            if (done) dt.push_back(cyc);
        end
        start = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        chk("b2b_runs", 32'(dt.size() >= 3), 32'd1);
        for (int i = 1; i < dt.size(); i++)
            chk("b2b_period", 32'(dt[i] - dt[i - 1]), 32'd8);
        check_results("b2b", 32'h0040_0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
